// File: rtl/sign_extension_unit.sv
// rtl/sign_extension_unit.sv - load-data byte/halfword/word extraction with sign/zero extension; optional lane select via SIGN_EXT_LANE_EN
module sign_extension_unit #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] D,
    input  logic [1:0]        dataSize,
    input  logic              E,
    input  logic              IN_VALID,
`ifdef SIGN_EXT_LANE_EN
    input  logic [1:0]        ADDR_LO,
`endif
    output logic [DATA_W-1:0] Q,
    output logic              OUT_VALID
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    logic [7:0]        byteField;
    logic [15:0]       halfField;
    logic [DATA_W-1:0] extended;

    // Select the addressed byte and halfword lanes of the memory word
    always_comb begin
        byteField = D[7:0];
        halfField = D[15:0];
`ifdef SIGN_EXT_LANE_EN
        case (ADDR_LO)
            2'd0:    byteField = D[7:0];
            2'd1:    byteField = D[15:8];
            2'd2:    byteField = D[23:16];
            default: byteField = D[31:24];
        endcase
        // Halfword accesses are aligned; the low offset bit does not matter
        halfField = ADDR_LO[1] ? D[31:16] : D[15:0];
`endif
    end

    // Widen the selected field; the sign bit is only replicated when E is set
    always_comb begin
        extended = D;
        case (dataSize)
            SIZE_BYTE: extended = {{(DATA_W-8){E & byteField[7]}}, byteField};
            SIZE_HALF: extended = {{(DATA_W-16){E & halfField[15]}}, halfField};
            default:   extended = D;
        endcase
    end

    // Output register: reset wins, Q holds between valid inputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            Q         <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= IN_VALID;
            if (IN_VALID) begin
                Q <= extended;
            end
        end
    end

endmodule

// File: tb/tb_sign_extension_unit.sv
// tb/tb_sign_extension_unit.sv - self-checking bench for sign_extension_unit
module tb_sign_extension_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] D;
    logic [1:0]  dataSize;
    logic        E;
    logic        IN_VALID;
    logic [1:0]  addrLo;
    logic [31:0] Q;
    logic        OUT_VALID;

    int checks = 0;
    int fails  = 0;

    logic [31:0] expQ;
    logic        expValid;
    logic        checkEn = 1'b0;

    sign_extension_unit #(.DATA_W(32)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .D(D),
        .dataSize(dataSize),
        .E(E),
        .IN_VALID(IN_VALID),
`ifdef SIGN_EXT_LANE_EN
        .ADDR_LO(addrLo),
`endif
        .Q(Q),
        .OUT_VALID(OUT_VALID)
    );

    always #5 CLK = ~CLK;

    // Reference: shift out the addressed field, then add the sign as plain arithmetic
    function automatic logic [31:0] refExtend(input logic [31:0] d, input logic [1:0] sz,
                                              input logic e, input logic [1:0] lo);
        longint unsigned field;
        longint unsigned width;
        longint unsigned shift;
        if (sz[1]) return d;
        width = (sz == 2'b00) ? 8 : 16;
        shift = 0;
`ifdef SIGN_EXT_LANE_EN
        shift = (sz == 2'b00) ? 64'(lo) * 8 : 64'(lo[1]) * 16;
`endif
        field = (64'(d) >> shift) % (64'd1 << width);
        if (e && field >= (64'd1 << (width - 1)))
            field = field + 64'h1_0000_0000 - (64'd1 << width);
        return field[31:0];
    endfunction

    // Apply one cycle of inputs, advance the model on the edge
    task automatic cycle(input logic r, input logic v, input logic [31:0] d,
                         input logic [1:0] s, input logic e, input logic [1:0] lo);
        RESET = r; IN_VALID = v; D = d; dataSize = s; E = e; addrLo = lo;
        @(posedge CLK);
        if (r) begin
            expQ = 32'h0; expValid = 1'b0;
        end else if (v) begin
            expQ = refExtend(d, s, e, lo); expValid = 1'b1;
        end else begin
            expValid = 1'b0;
        end
        #1;
    endtask

    task automatic expectLit(input string name, input logic [31:0] q, input logic ov);
        @(negedge CLK);
        #1;
        checks++;
        if (Q !== q || OUT_VALID !== ov) begin
            fails++;
            $display("FAIL %s: got Q=%h OUT_VALID=%b, need Q=%h OUT_VALID=%b", name, Q, OUT_VALID, q, ov);
        end
    endtask

    // Every cycle after the first reset, outputs must match the model
    always @(negedge CLK) begin
        if (checkEn) begin
            checks++;
            if (Q !== expQ || OUT_VALID !== expValid) begin
                fails++;
                $display("FAIL model_cmp t=%0t: got Q=%h OUT_VALID=%b, need Q=%h OUT_VALID=%b",
                         $time, Q, OUT_VALID, expQ, expValid);
            end
        end
    end

    initial begin
        // Reset for two edges with a valid input that must be discarded
        cycle(1, 1, 32'hFFFFFFFF, 2'b10, 1, 2'd0);
        checkEn = 1'b1;
        cycle(1, 1, 32'hFFFFFFFF, 2'b10, 1, 2'd0);
        expectLit("reset", 32'h0, 1'b0);
        cycle(0, 0, 32'hFFFFFFFF, 2'b10, 1, 2'd0);
        expectLit("post_reset_idle", 32'h0, 1'b0);

        cycle(0, 1, 32'h0000FF03, 2'b00, 0, 2'd0); expectLit("byte_zx", 32'h00000003, 1'b1);
        cycle(0, 1, 32'h0000FF03, 2'b00, 1, 2'd0); expectLit("byte_sx_pos", 32'h00000003, 1'b1);
        cycle(0, 1, 32'h0000FF03, 2'b01, 0, 2'd0); expectLit("half_zx", 32'h0000FF03, 1'b1);
        cycle(0, 1, 32'h0000FF03, 2'b01, 1, 2'd0); expectLit("half_sx_neg", 32'hFFFFFF03, 1'b1);
        cycle(0, 1, 32'hF0E47492, 2'b00, 0, 2'd0); expectLit("byte_zx_92", 32'h00000092, 1'b1);

        // Back-to-back throughput, each result one cycle after its input
        cycle(0, 1, 32'hF0E47492, 2'b00, 1, 2'd0);
        cycle(0, 1, 32'hF0E47492, 2'b01, 1, 2'd0);
        cycle(0, 1, 32'hF0E47492, 2'b10, 1, 2'd0);
        cycle(0, 1, 32'hF0E47492, 2'b11, 1, 2'd0);
        expectLit("word_rsvd", 32'hF0E47492, 1'b1);
        cycle(0, 0, 32'h12345678, 2'b00, 1, 2'd0);
        expectLit("idle_hold", 32'hF0E47492, 1'b0);

        // Throughput again, checking each step against literals
        cycle(0, 1, 32'hF0E47492, 2'b00, 1, 2'd0); expectLit("tp_byte", 32'hFFFFFF92, 1'b1);
        cycle(0, 1, 32'hF0E47492, 2'b01, 1, 2'd0); expectLit("tp_half", 32'h00007492, 1'b1);
        cycle(0, 1, 32'hF0E47492, 2'b10, 1, 2'd0); expectLit("tp_word", 32'hF0E47492, 1'b1);

        // Reset colliding with a valid input
        cycle(1, 1, 32'h000000FF, 2'b00, 1, 2'd0);
        expectLit("reset_midstream", 32'h0, 1'b0);

`ifdef SIGN_EXT_LANE_EN
        cycle(0, 1, 32'hF0E47492, 2'b00, 1, 2'd3); expectLit("lane_b3", 32'hFFFFFFF0, 1'b1);
        cycle(0, 1, 32'hF0E47492, 2'b00, 1, 2'd2); expectLit("lane_b2", 32'hFFFFFFE4, 1'b1);
        cycle(0, 1, 32'hF0E47492, 2'b01, 1, 2'd2); expectLit("lane_h2", 32'hFFFFF0E4, 1'b1);
        cycle(0, 1, 32'hF0E47492, 2'b00, 0, 2'd1); expectLit("lane_b1_zx", 32'h00000074, 1'b1);
        cycle(0, 1, 32'hF0E47492, 2'b01, 0, 2'd3); expectLit("lane_h3_zx", 32'h0000F0E4, 1'b1);
        cycle(0, 1, 32'hF0E47492, 2'b10, 1, 2'd3); expectLit("lane_word", 32'hF0E47492, 1'b1);
`else
        cycle(0, 1, 32'hF0E47492, 2'b00, 1, 2'd3); expectLit("nolane_byte", 32'hFFFFFF92, 1'b1);
        cycle(0, 1, 32'hF0E48092, 2'b01, 0, 2'd2); expectLit("nolane_half", 32'h00008092, 1'b1);
`endif

        // Randomized traffic with occasional resets and idle cycles
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        @(negedge CLK);
        #2;
        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
